// File: rtl/qwiregmst.sv
// Single-outstanding command master driving a BRAM-style register bus.
// Out-of-range commands are answered locally with an error and counted.
module qwiregmst #(
    parameter int unsigned REGCNT = 2,
    parameter int unsigned AWID   = 9,
    parameter int unsigned DWID   = 32,
    parameter int unsigned RDLAT  = 1,
    localparam int unsigned BW    = DWID / 8
) (
    input  logic            reg_clk_i,
    input  logic            sys_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_wr_i,
    input  logic [AWID-1:0] cmd_addr_i,
    input  logic [DWID-1:0] cmd_wdata_i,
    input  logic [BW-1:0]   cmd_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_wr_o,
    output logic            rsp_err_o,
    output logic [DWID-1:0] rsp_rdata_o,
    output logic            reg_ce_o,
    output logic [BW-1:0]   reg_we_o,
    output logic [AWID-1:0] reg_addr_o,
    output logic [DWID-1:0] reg_wrd_o,
    input  logic [DWID-1:0] reg_rdd_i,
    output logic [7:0]      err_cnt_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdwait, StResp} state_e;

    state_e          state_q, state_d;
    logic            rdy_q;
    logic            wr_q, wr_d;
    logic [BW-1:0]   be_q, be_d;
    logic [AWID-1:0] addr_q, addr_d;
    logic [DWID-1:0] wrd_q, wrd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rsp_wr_q, rsp_wr_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DWID-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            bad_addr;

    assign bad_addr = 32'(cmd_addr_i) >= REGCNT;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wrd_d       = wrd_q;
        cnt_d       = cnt_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && rdy_q) begin
                    wr_d = cmd_wr_i;
                    if (bad_addr) begin
                        rsp_wr_d    = cmd_wr_i;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        state_d = StResp;
                    end else begin
                        // Bus-side address/data only move for commands that reach the bus
                        be_d    = cmd_be_i;
                        addr_d  = cmd_addr_i;
                        wrd_d   = cmd_wdata_i;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (wr_q) begin
                    rsp_wr_d    = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d   = 3'(RDLAT - 1);
                    state_d = StRdwait;
                end
            end
            StRdwait: begin
                if (cnt_q == 3'd0) begin
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = reg_rdd_i;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge reg_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b0;
            wr_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wrd_q       <= '0;
            cnt_q       <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            wr_q        <= wr_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wrd_q       <= wrd_d;
            cnt_q       <= cnt_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // rdy_q keeps cmd_ready low during reset and until the first clock after release
    assign cmd_ready_o = rdy_q && (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_wr_o    = rsp_wr_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign reg_ce_o    = (state_q == StIssue);
    assign reg_we_o    = (state_q == StIssue && wr_q) ? be_q : '0;
    assign reg_addr_o  = addr_q;
    assign reg_wrd_o   = wrd_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_qwiregmst.sv
// Scoreboard bench for qwiregmst: three instances with RDLAT 1, 2 and 4 share
// the command/response inputs; instance 0 is fully scoreboarded.
module tb_qwiregmst;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef struct packed {
        logic          wr;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic [BW-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wrd;
    } ce_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [BW-1:0] cmd_be = '0;
    logic          rsp_ready = 1'b0;

    logic          cr [3];
    logic          rv [3];
    logic          rw [3];
    logic          re [3];
    logic          ce [3];
    logic [BW-1:0] we [3];
    logic [AW-1:0] ra [3];
    logic [DW-1:0] wrd [3];
    logic [DW-1:0] rd [3];
    logic [DW-1:0] rdd [3];
    logic [7:0]    ec [3];
    int            rise_cyc_a [3];
    logic [DW-1:0] rise_dat_a [3];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ce_cnt = 0;
    rsp_t rsp_q[$];
    ce_t  ce_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return (a == '0) ? 32'h1904_2101 : {23'h05A5A5, a};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [DW-1:0] pipe [4];
        logic          rv_prev = 1'b0;
        int            rise_cyc = -1000;
        logic [DW-1:0] rise_dat = '0;

        qwiregmst #(.REGCNT(2), .AWID(AW), .DWID(DW), .RDLAT(Lat)) u_dut (
            .reg_clk_i  (clk),
            .sys_rst_ni (rst_n),
            .cmd_valid_i(cmd_valid),
            .cmd_ready_o(cr[g]),
            .cmd_wr_i   (cmd_wr),
            .cmd_addr_i (cmd_addr),
            .cmd_wdata_i(cmd_wdata),
            .cmd_be_i   (cmd_be),
            .rsp_valid_o(rv[g]),
            .rsp_ready_i(rsp_ready),
            .rsp_wr_o   (rw[g]),
            .rsp_err_o  (re[g]),
            .rsp_rdata_o(rd[g]),
            .reg_ce_o   (ce[g]),
            .reg_we_o   (we[g]),
            .reg_addr_o (ra[g]),
            .reg_wrd_o  (wrd[g]),
            .reg_rdd_i  (rdd[g]),
            .err_cnt_o  (ec[g])
        );

        // Responder: read data appears only in the one cycle Lat clocks after the ce cycle
        always @(posedge clk) begin
            pipe[0] <= ce[g] ? rd_model(ra[g]) : 32'hDEAD_BEEF;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign rdd[g] = pipe[Lat-1];

        always @(negedge clk) begin
            if (rv[g] && !rv_prev) begin
                rise_cyc = cyc;
                rise_dat = rd[g];
            end
            rv_prev = rv[g];
        end
        assign rise_cyc_a[g] = rise_cyc;
        assign rise_dat_a[g] = rise_dat;
    end

    // Scoreboard monitor for instance 0
    always @(negedge clk) begin
        rsp_t r;
        ce_t  c;
        if (rst_n && rv[0] && rsp_ready) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got wr=%0b err=%0b data=%h, none expected",
                         rw[0], re[0], rd[0]);
            end else begin
                r = rsp_q.pop_front();
                if ({rw[0], re[0], rd[0]} !== r) begin
                    n_err++;
                    $display("FAIL rsp_fields: got wr=%0b err=%0b data=%h, want wr=%0b err=%0b data=%h",
                             rw[0], re[0], rd[0], r.wr, r.err, r.data);
                end
            end
        end
        if (rst_n && ce[0]) begin
            ce_cnt++;
            n_vec++;
            if (ce_q.size() == 0) begin
                n_err++;
                $display("FAIL ce_unexpected: got ce with addr=%h we=%h", ra[0], we[0]);
            end else begin
                c = ce_q.pop_front();
                if ({we[0], ra[0], wrd[0]} !== c) begin
                    n_err++;
                    $display("FAIL ce_fields: got we=%h addr=%h wrd=%h, want we=%h addr=%h wrd=%h",
                             we[0], ra[0], wrd[0], c.we, c.addr, c.wrd);
                end
            end
        end
    end

    function automatic logic [89:0] outs0();
        return {cr[0], rv[0], rw[0], re[0], ce[0], we[0], ra[0], wrd[0], rd[0], ec[0]};
    endfunction

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
        rsp_t r;
        ce_t  c;
        cmd_wr = wr;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_be = be;
        cmd_valid = 1'b1;
        if (a >= 2) begin
            r = '{wr: wr, err: 1'b1, data: '0};
        end else begin
            c = '{we: (wr ? be : '0), addr: a, wrd: d};
            ce_q.push_back(c);
            r = '{wr: wr, err: 1'b0, data: (wr ? '0 : rd_model(a))};
        end
        rsp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!(cr[0] && cr[1] && cr[2]) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: cmd_ready not seen within 200 cycles");
        end
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, output int acc);
        wait_idle();
        drive(wr, a, d, be);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        // Scramble the command bus; the latched copy must be used
        cmd_wr = ~wr;
        cmd_addr = ~a;
        cmd_wdata = ~d;
        cmd_be = ~be;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (outs0() !== '0) begin
            n_err++;
            $display("FAIL reset_values: got %h, want 0", outs0());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (cr[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %0b, want 0", cr[0]);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (cr[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_first_edge: got %0b, want 1", cr[0]);
        end
    endtask

    task automatic test_write();
        int acc;
        int ce0;
        rsp_ready = 1'b1;
        ce0 = ce_cnt;
        send(1'b1, 9'd1, 32'h0000_0001, 4'hF, acc);
        wait_idle();
        n_vec++;
        if (rise_cyc_a[0] - acc + 1 !== 2) begin
            n_err++;
            $display("FAIL write_latency: got %0d, want 2", rise_cyc_a[0] - acc + 1);
        end
        n_vec++;
        if (ce_cnt - ce0 !== 1) begin
            n_err++;
            $display("FAIL write_ce_count: got %0d, want 1", ce_cnt - ce0);
        end
        // Byte enables of zero still produce a bus cycle and a normal response
        send(1'b1, 9'd0, 32'hA5A5_5A5A, 4'h0, acc);
        wait_idle();
        n_vec++;
        if (ce_cnt - ce0 !== 2) begin
            n_err++;
            $display("FAIL be0_ce_count: got %0d, want 2", ce_cnt - ce0);
        end
    endtask

    task automatic test_read_lat();
        int acc;
        logic [AW-1:0] a;
        for (int k = 0; k < 2; k++) begin
            a = AW'(k);
            send(1'b0, a, 32'h1234_5678, 4'hF, acc);
            wait_idle();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if (rise_cyc_a[g] - acc + 1 !== 2 + lat_of(g)) begin
                    n_err++;
                    $display("FAIL read_latency[rdlat=%0d]: got %0d, want %0d", lat_of(g),
                             rise_cyc_a[g] - acc + 1, 2 + lat_of(g));
                end
                n_vec++;
                if (rise_dat_a[g] !== rd_model(a)) begin
                    n_err++;
                    $display("FAIL read_data[rdlat=%0d]: got %h, want %h", lat_of(g),
                             rise_dat_a[g], rd_model(a));
                end
            end
        end
    endtask

    task automatic test_reject();
        int acc;
        int ce0;
        n_vec++;
        if (ec[0] !== 8'd0) begin
            n_err++;
            $display("FAIL err_cnt_start: got %0d, want 0", ec[0]);
        end
        ce0 = ce_cnt;
        send(1'b0, 9'd5, 32'h0, 4'hF, acc);
        n_vec++;
        if (ec[0] !== 8'd1) begin
            n_err++;
            $display("FAIL err_cnt_one: got %0d, want 1", ec[0]);
        end
        wait_idle();
        n_vec++;
        if (rise_cyc_a[0] - acc + 1 !== 1) begin
            n_err++;
            $display("FAIL reject_latency: got %0d, want 1", rise_cyc_a[0] - acc + 1);
        end
        send(1'b1, 9'd2, 32'hFFFF_FFFF, 4'hF, acc);
        wait_idle();
        n_vec++;
        if (ec[0] !== 8'd2 || ce_cnt !== ce0) begin
            n_err++;
            $display("FAIL reject_boundary: got err_cnt=%0d ce=%0d, want 2 and %0d", ec[0],
                     ce_cnt, ce0);
        end
    endtask

    task automatic test_stall();
        int acc;
        int g = 0;
        int ce0;
        rsp_ready = 1'b0;
        ce0 = ce_cnt;
        send(1'b0, 9'd1, 32'h0, 4'hF, acc);
        @(negedge clk);
        while (!rv[0] && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_rsp_timeout: rsp_valid not seen");
        end
        drive(1'b1, 9'd0, 32'h0000_0055, 4'h3);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (rv[0] !== 1'b1 || rd[0] !== rd_model(9'd1) || cr[0] !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%0b data=%h ready=%0b, want 1 %h 0",
                         rv[0], rd[0], cr[0], rd_model(9'd1));
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (cr[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pending_accept: got ready=%0b, want 1", cr[0]);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();
        n_vec++;
        if (ce_cnt - ce0 !== 2) begin
            n_err++;
            $display("FAIL stall_ce_count: got %0d, want 2", ce_cnt - ce0);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int k = 0;
        int guard = 0;
        int ce0;
        rsp_ready = 1'b1;
        wait_idle();
        ce0 = ce_cnt;
        drive(1'b1, 9'd0, 32'h0000_0100, 4'hF);
        while (k < 6 && guard < 100) begin
            guard++;
            if (cr[0]) begin
                @(posedge clk);
                #1;
                acc.push_back(cyc);
                k++;
                if (k < 6) drive(1'b1, AW'(k % 2), 32'h0000_0100 + DW'(k), 4'(k + 1));
                else cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        if (k < 6) begin
            n_vec++;
            n_err++;
            cmd_valid = 1'b0;
            $display("FAIL b2b_timeout: got %0d accepts, want 6", k);
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_vec++;
            if (acc[i] - acc[i-1] !== 3) begin
                n_err++;
                $display("FAIL b2b_spacing[%0d]: got %0d, want 3", i, acc[i] - acc[i-1]);
            end
        end
        wait_idle();
        n_vec++;
        if (ce_cnt - ce0 !== 6) begin
            n_err++;
            $display("FAIL b2b_ce_count: got %0d, want 6", ce_cnt - ce0);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int seen;
        rsp_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            send(1'b0, 9'd1, 32'hCAFE_0000, 4'hF, acc);
            if (ph == 0) begin
                #1;
                n_vec++;
                if (ce[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL issue_ce: got %0b, want 1", ce[0]);
                end
            end else begin
                @(negedge clk);
            end
            rst_n = 1'b0;
            #1;
            n_vec++;
            if (outs0() !== '0) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %h, want 0", ph, outs0());
            end
            rsp_q.delete();
            ce_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rv[0] || ce[0]) seen++;
            end
            n_vec++;
            if (seen !== 0) begin
                n_err++;
                $display("FAIL reset_no_rsp[%0d]: got %0d active cycles, want 0", ph, seen);
            end
        end
        send(1'b0, 9'd0, 32'h0, 4'hF, acc);
        wait_idle();
        n_vec++;
        if (rise_cyc_a[0] - acc + 1 !== 3) begin
            n_err++;
            $display("FAIL post_reset_read: got latency %0d, want 3", rise_cyc_a[0] - acc + 1);
        end
    endtask

    task automatic test_saturate();
        int acc;
        rsp_ready = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            send(1'(i % 2), 9'd5 + AW'(i % 7), DW'(i), 4'hF, acc);
            if (i == 254 || i == 255 || i == 260) begin
                n_vec++;
                if (ec[0] !== ((i < 255) ? 8'(i) : 8'd255)) begin
                    n_err++;
                    $display("FAIL err_cnt_sat[%0d]: got %0d, want %0d", i, ec[0],
                             (i < 255) ? i : 255);
                end
            end
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_lat();
        test_reject();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        n_vec++;
        if (rsp_q.size() != 0 || ce_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d rsp and %0d ce left, want 0 and 0",
                     rsp_q.size(), ce_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
